// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: store/load op encodings
// and the store-buffer entry layout.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_NONE = 2'b00,
      ST_SB   = 2'b01,
      ST_SH   = 2'b10,
      ST_SW   = 2'b11
   } st_op_t;

   typedef enum logic [2:0] {
      LD_NONE = 3'b000,
      LD_LB   = 3'b001,
      LD_LBU  = 3'b010,
      LD_LH   = 3'b011,
      LD_LHU  = 3'b100,
      LD_LW   = 3'b101
   } ld_op_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [31:0] wdata;
   } st_entry_t;

endpackage

// File: rtl/storefmt.sv
// Store formatter: alignment check, lane replication and
// byte-enable generation for SB/SH/SW.
module storefmt
   import mem_pkg::*;
(
   input  logic [1:0]  st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic [31:0] addr,
   output logic [3:0]  wen,
   output logic [31:0] wdata,
   output logic        misaligned
);

   always_comb begin
      addr       = {st_addr[31:2], 2'b00};
      wen        = 4'b0000;
      wdata      = 32'h0;
      misaligned = 1'b0;
      unique case (st_op)
         ST_SB: begin
            wdata = {4{st_data[7:0]}};
            wen   = 4'b0001 << st_addr[1:0];
         end
         ST_SH: begin
            wdata      = {2{st_data[15:0]}};
            wen        = st_addr[1] ? 4'b1100 : 4'b0011;
            misaligned = st_addr[0];
         end
         ST_SW: begin
            wdata      = st_data;
            wen        = 4'b1111;
            misaligned = |st_addr[1:0];
         end
         ST_NONE: begin
         end
      endcase
   end

endmodule

// File: rtl/dmwrite.sv
// In-order store buffer between the MEM stage and the
// data-memory write port, drained under req/gnt.
module dmwrite
   import mem_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid,
   input  logic [1:0]  st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_ready,
   output logic        st_ades,
   output logic        buf_empty,
   output logic        p_data_req,
   output logic [31:0] p_data_addr,
   output logic [3:0]  p_data_wen,
   output logic [31:0] p_data_wdata,
   input  logic        p_data_gnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   st_entry_t       mem_q [DEPTH];
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [CW-1:0]   count;

   logic [31:0]     f_addr;
   logic [3:0]      f_wen;
   logic [31:0]     f_wdata;
   logic            f_mis;
   logic            push;
   logic            pop;
   st_entry_t       head_ent;

   storefmt u_fmt (
      .st_op      (st_op),
      .st_addr    (st_addr),
      .st_data    (st_data),
      .addr       (f_addr),
      .wen        (f_wen),
      .wdata      (f_wdata),
      .misaligned (f_mis)
   );

   assign buf_empty  = (count == '0);
   assign st_ready   = (count != CW'(DEPTH));
   assign st_ades    = st_valid && f_mis;
   assign push       = st_valid && (st_op != ST_NONE)
                       && st_ready && !f_mis;
   assign p_data_req = !buf_empty;
   assign pop        = p_data_req && p_data_gnt;

   // Head fields are masked so the port reads zero when idle.
   assign head_ent     = buf_empty ? '0 : mem_q[head];
   assign p_data_addr  = head_ent.addr;
   assign p_data_wen   = head_ent.wen;
   assign p_data_wdata = head_ent.wdata;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[tail] <= '{addr: f_addr, wen: f_wen, wdata: f_wdata};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_dmwrite.sv
// Scoreboard bench for dmwrite: stimulus queues expected
// entries, a negedge monitor checks each granted write.
module tb_dmwrite;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        st_ades;
   logic        buf_empty;
   logic        p_data_req;
   logic [31:0] p_data_addr;
   logic [3:0]  p_data_wen;
   logic [31:0] p_data_wdata;
   logic        p_data_gnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   st_entry_t exp_q [$];

   always #5 clk = ~clk;

   dmwrite #(.DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .st_valid     (st_valid),
      .st_op        (st_op),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .st_ready     (st_ready),
      .st_ades      (st_ades),
      .buf_empty    (buf_empty),
      .p_data_req   (p_data_req),
      .p_data_addr  (p_data_addr),
      .p_data_wen   (p_data_wen),
      .p_data_wdata (p_data_wdata),
      .p_data_gnt   (p_data_gnt)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   // Monitor: pops on each handshake, checks hold stability.
   st_entry_t hold_ent;
   logic      hold = 1'b0;

   always @(negedge clk) begin
      st_entry_t cur;
      st_entry_t e;
      cur = '{addr: p_data_addr, wen: p_data_wen, wdata: p_data_wdata};
      if (p_data_req && hold) chk("stable", cur[67:36], hold_ent[67:36]);
      if (p_data_req && p_data_gnt) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pop", p_data_addr, 32'hDEAD_DEAD);
         end else begin
            e = exp_q.pop_front();
            chk("addr", p_data_addr, e.addr);
            chk("wen", {28'h0, p_data_wen}, {28'h0, e.wen});
            chk("wdata", p_data_wdata, e.wdata);
         end
      end
      hold     = p_data_req && !p_data_gnt;
      hold_ent = cur;
   end

   task automatic store(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d, input bit e_ades,
                        input bit e_acc, input logic [3:0] e_wen,
                        input logic [31:0] e_wdata,
                        input logic [31:0] e_addr);
      st_valid = 1'b1;
      st_op    = op;
      st_addr  = a;
      st_data  = d;
      #1;
      chk("ades", {31'h0, st_ades}, {31'h0, e_ades});
      if (e_acc) exp_q.push_back('{addr: e_addr, wen: e_wen, wdata: e_wdata});
      @(posedge clk);
      #1;
      st_valid = 1'b0;
      st_op    = 2'b00;
   endtask

   initial begin
      rst        = 1'b1;
      st_valid   = 1'b0;
      st_op      = 2'b00;
      st_addr    = 32'h0;
      st_data    = 32'h0;
      p_data_gnt = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'h0, p_data_req}, 32'h0);
      chk("rst_empty", {31'h0, buf_empty}, 32'h1);
      chk("rst_ready", {31'h0, st_ready}, 32'h1);
      chk("rst_addr", p_data_addr, 32'h0);
      chk("rst_wdata", p_data_wdata, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // SB lane steering, grant tied high
      p_data_gnt = 1'b1;
      store(ST_SB, 32'h100, 32'hA5, 0, 1, 4'b0001, 32'hA5A5A5A5, 32'h100);
      store(ST_SB, 32'h101, 32'hA5, 0, 1, 4'b0010, 32'hA5A5A5A5, 32'h100);
      store(ST_SB, 32'h102, 32'hA5, 0, 1, 4'b0100, 32'hA5A5A5A5, 32'h100);
      store(ST_SB, 32'h103, 32'hA5, 0, 1, 4'b1000, 32'hA5A5A5A5, 32'h100);
      @(posedge clk);
      #1;
      chk("sb_drained", {31'h0, buf_empty}, 32'h1);

      // SH upper half, latency check with grant low
      p_data_gnt = 1'b0;
      store(ST_SH, 32'h202, 32'h1234BEEF, 0, 1, 4'b1100, 32'hBEEFBEEF,
            32'h200);
      chk("sh_req_n1", {31'h0, p_data_req}, 32'h1);
      p_data_gnt = 1'b1;
      @(posedge clk);
      #1;
      p_data_gnt = 1'b0;
      chk("sh_drained", {31'h0, buf_empty}, 32'h1);

      // Misaligned stores and the no-op
      store(ST_SH, 32'h201, 32'h1234BEEF, 1, 0, 4'b0, 32'h0, 32'h0);
      chk("sh_mis_empty", {31'h0, buf_empty}, 32'h1);
      store(ST_SW, 32'h302, 32'h0BADF00D, 1, 0, 4'b0, 32'h0, 32'h0);
      chk("sw_mis_empty", {31'h0, buf_empty}, 32'h1);
      store(ST_NONE, 32'h101, 32'hFFFFFFFF, 0, 0, 4'b0, 32'h0, 32'h0);
      chk("noop_empty", {31'h0, buf_empty}, 32'h1);

      // Fill to full, third push refused, then ordered drain
      store(ST_SW, 32'h300, 32'h11111111, 0, 1, 4'b1111, 32'h11111111,
            32'h300);
      chk("one_ready", {31'h0, st_ready}, 32'h1);
      store(ST_SW, 32'h304, 32'h22222222, 0, 1, 4'b1111, 32'h22222222,
            32'h304);
      chk("full_ready", {31'h0, st_ready}, 32'h0);
      store(ST_SW, 32'h308, 32'h33333333, 0, 0, 4'b0, 32'h0, 32'h0);
      chk("full_still", {31'h0, st_ready}, 32'h0);
      p_data_gnt = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("full_drained", {31'h0, buf_empty}, 32'h1);
      p_data_gnt = 1'b0;

      // Push and pop together at count==1
      store(ST_SW, 32'h400, 32'hAAAA0000, 0, 1, 4'b1111, 32'hAAAA0000,
            32'h400);
      p_data_gnt = 1'b1;
      store(ST_SW, 32'h404, 32'hBBBB0001, 0, 1, 4'b1111, 32'hBBBB0001,
            32'h404);
      p_data_gnt = 1'b0;
      chk("c1_req", {31'h0, p_data_req}, 32'h1);
      chk("c1_ready", {31'h0, st_ready}, 32'h1);
      chk("c1_head", p_data_wdata, 32'hBBBB0001);
      @(posedge clk);
      #1;
      p_data_gnt = 1'b1;
      @(posedge clk);
      #1;
      p_data_gnt = 1'b0;
      chk("c1_drained", {31'h0, buf_empty}, 32'h1);

      // Asynchronous reset with two entries pending
      store(ST_SW, 32'h500, 32'h55555555, 0, 0, 4'b0, 32'h0, 32'h0);
      store(ST_SW, 32'h504, 32'h66666666, 0, 0, 4'b0, 32'h0, 32'h0);
      chk("pre_rst_ready", {31'h0, st_ready}, 32'h0);
      #1 rst = 1'b1;
      #1;
      chk("arst_req", {31'h0, p_data_req}, 32'h0);
      chk("arst_ready", {31'h0, st_ready}, 32'h1);
      chk("arst_empty", {31'h0, buf_empty}, 32'h1);
      chk("arst_wen", {28'h0, p_data_wen}, 32'h0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Post-reset sanity: SH lower half
      p_data_gnt = 1'b1;
      store(ST_SH, 32'h600, 32'hCAFE5A5A, 0, 1, 4'b0011, 32'h5A5A5A5A,
            32'h600);

      begin
         int n;
         n = 0;
         while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
         end
         #1;
         chk("drain_timeout", exp_q.size(), 32'h0);
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
